// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings for the MEM-stage data memory controller
package mem_access_pkg;

  localparam int MEM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/ls_lane_align.sv
// rtl/ls_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module ls_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = word[{off, 3'b000} +: 8];
    half_v    = word[{off[1], 4'b0000} +: 16];
    load_data = word;
    merged    = word;
    case (size)
      SIZE_B: begin
        load_data = {{24{sgn & byte_v[7]}}, byte_v};
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        load_data = {{16{sgn & half_v[15]}}, half_v};
        merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SIZE_W: begin
        load_data = word;
        merged    = wdata;
      end
      default: begin
        load_data = word;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store initiator with sub-word read-modify-write and trap
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic        we_q, signed_q, err_q;
  size_e       size_q, req_size_e;
  logic [1:0]  off_q;
  logic [31:0] wdata_q, addr_q, word_q;
  logic [31:0] req_word_addr;
  logic        accept, req_err;
  logic [31:0] load_data, merged;

  assign req_size_e    = size_e'(req_size);
  assign req_word_addr = {req_addr[31:2], 2'b00};
  assign accept        = req_valid && (state_q == ST_IDLE);

  // Trapped requests skip memory entirely and go straight to the response.
  assign req_err = (req_size_e == SIZE_X)
                 | ((req_size_e == SIZE_H) & req_addr[0])
                 | ((req_size_e == SIZE_W) & (req_addr[1:0] != 2'b00))
                 | (req_word_addr > LAST_WORD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)
            state_d = ST_RESP;
          else if (req_we && (req_size_e == SIZE_W))
            state_d = ST_WR;
          else
            state_d = ST_RD;
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= SIZE_B;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      addr_q   <= 32'h0;
      word_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size_e;
        signed_q <= req_signed;
        err_q    <= req_err;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        addr_q   <= req_word_addr;
      end
      if (state_q == ST_RD)
        word_q <= rd;
    end
  end

  ls_lane_align u_align (
    .word      (word_q),
    .off       (off_q),
    .size      (size_q),
    .sgn       (signed_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) && err_q;
  assign resp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? load_data : 32'h0;
  assign MemRead    = (state_q == ST_RD);
  assign MemWrite   = (state_q == ST_WR);
  assign addr       = addr_q;
  assign wd         = (state_q == ST_WR) ? merged : 32'h0;

endmodule
